// File: rtl/trace_drain_scheduler.sv
// Trace record buffer: start/stop capture FSM feeding a fall-through FIFO,
// drained to the sink over valid/ready, with a saturating drop counter.
module trace_drain_scheduler #(
  parameter int REC_WIDTH = 128,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_start_i,
  input  logic                   ctrl_stop_i,
  input  logic                   rec_valid_i,
  input  logic [REC_WIDTH-1:0]   rec_data_i,
  output logic                   out_valid_o,
  output logic [REC_WIDTH-1:0]   out_data_o,
  input  logic                   out_ready_i,
  output logic [1:0]             state_o,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic [CNT_WIDTH-1:0]   drop_count_o,
  output logic                   overflow_o,
  output logic                   done_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_F = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            fill_q, fill_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;
  logic [REC_WIDTH-1:0]   mem_q [DEPTH];
  logic                   push, pop, drop;

  always_comb begin
    pop  = (fill_q != '0) && out_ready_i && (state_q != IDLE);
    push = (state_q == CAPTURE) && rec_valid_i && ((fill_q < DEPTH_F) || pop);
    drop = (state_q == CAPTURE) && rec_valid_i && !push;

    state_d  = state_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d   = fill_q + (AW+1)'(push) - (AW+1)'(pop);
    drop_d   = (drop && drop_q != '1) ? drop_q + CNT_WIDTH'(1) : drop_q;
    ovf_d    = ovf_q | drop;

    unique case (state_q)
      IDLE:    if (ctrl_start_i) state_d = CAPTURE;
      CAPTURE: if (ctrl_stop_i)  state_d = DRAIN;
      // fill==0 here means nothing left to pop and pushes are already closed
      DRAIN:   if (fill_q == '0) state_d = DONE;
      DONE:    if (ctrl_start_i) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase

    if ((state_q == IDLE || state_q == DONE) && ctrl_start_i) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: pointers and fill define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rec_data_i;
  end

  assign out_valid_o  = (fill_q != '0);
  assign out_data_o   = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign state_o      = state_q;
  assign fill_o       = fill_q;
  assign drop_count_o = drop_q;
  assign overflow_o   = ovf_q;
  assign done_o       = done_q;
endmodule

// File: tb/tb_trace_drain_scheduler.sv
// Directed bench for trace_drain_scheduler: table-driven basic flow plus
// hand-written overflow, drain, reset and restart sequences.
module tb_trace_drain_scheduler;
  logic         clk = 1'b0;
  logic         rst, start, stop, rvalid, ordy;
  logic [127:0] rdata;
  logic         ovalid, ovf, done;
  logic [127:0] odata;
  logic [1:0]   state;
  logic [4:0]   fill;
  logic [31:0]  dropc;

  int checks = 0;
  int errors = 0;

  trace_drain_scheduler #(.REC_WIDTH(128), .DEPTH(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ctrl_start_i(start), .ctrl_stop_i(stop),
    .rec_valid_i(rvalid), .rec_data_i(rdata),
    .out_valid_o(ovalid), .out_data_o(odata), .out_ready_i(ordy),
    .state_o(state), .fill_o(fill), .drop_count_o(dropc),
    .overflow_o(ovf), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, sp, v, rdy;
    logic [127:0] d;
    logic [1:0]   e_state;
    logic [4:0]   e_fill;
    logic         e_valid;
    logic [127:0] e_data;
    logic         e_done;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one posedge, return 1 time unit after it.
  task automatic cyc(input logic st, input logic sp, input logic v,
                     input logic [127:0] d, input logic rdy);
    start = st; stop = sp; rvalid = v; rdata = d; ordy = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] exp_q[$];
    int xfers;
    bit reached;

    // start with a record on the same cycle: record ignored
    tbl[0] = '{st:1, sp:0, v:1, rdy:1, d:128'hA0, e_state:1, e_fill:0, e_valid:0, e_data:0, e_done:0};
    tbl[1] = '{st:0, sp:0, v:1, rdy:1, d:128'h1,  e_state:1, e_fill:1, e_valid:1, e_data:1, e_done:0};
    tbl[2] = '{st:0, sp:0, v:1, rdy:1, d:128'h2,  e_state:1, e_fill:1, e_valid:1, e_data:2, e_done:0};
    tbl[3] = '{st:0, sp:0, v:1, rdy:1, d:128'h3,  e_state:1, e_fill:1, e_valid:1, e_data:3, e_done:0};
    tbl[4] = '{st:0, sp:0, v:0, rdy:1, d:128'h0,  e_state:1, e_fill:0, e_valid:0, e_data:0, e_done:0};
    tbl[5] = '{st:0, sp:1, v:0, rdy:1, d:128'h0,  e_state:2, e_fill:0, e_valid:0, e_data:0, e_done:0};
    tbl[6] = '{st:0, sp:0, v:0, rdy:1, d:128'h0,  e_state:3, e_fill:0, e_valid:0, e_data:0, e_done:1};
    tbl[7] = '{st:1, sp:0, v:0, rdy:1, d:128'h0,  e_state:1, e_fill:0, e_valid:0, e_data:0, e_done:0};

    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("reset_state", 128'(state), 0);
    chk("reset_fill",  128'(fill), 0);
    chk("reset_valid", 128'(ovalid), 0);
    chk("reset_data",  odata, 0);
    chk("reset_drop",  128'(dropc), 0);
    chk("reset_ovf",   128'(ovf), 0);
    chk("reset_done",  128'(done), 0);
    rst = 1'b0;
    // idle: stop and records ignored
    cyc(0, 1, 1, 128'h55, 1);
    chk("idle_stop_ignored", 128'(state), 0);
    chk("idle_no_push", 128'(fill), 0);

    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].st, tbl[i].sp, tbl[i].v, tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_state", i), 128'(state), 128'(tbl[i].e_state));
      chk($sformatf("tbl%0d_fill", i),  128'(fill),  128'(tbl[i].e_fill));
      chk($sformatf("tbl%0d_valid", i), 128'(ovalid), 128'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_data", i),  odata, tbl[i].e_data);
      chk($sformatf("tbl%0d_done", i),  128'(done), 128'(tbl[i].e_done));
      chk($sformatf("tbl%0d_drop", i),  128'(dropc), 0);
    end

    // overflow: 20 records, no ready
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 128'(100 + i), 0);
    chk("ovf_fill", 128'(fill), 16);
    chk("ovf_drop", 128'(dropc), 4);
    chk("ovf_sticky", 128'(ovf), 1);
    chk("ovf_head", odata, 100);
    // held stable under back-pressure
    cyc(0, 0, 0, 0, 0);
    chk("hold_data", odata, 100);
    chk("hold_valid", 128'(ovalid), 1);
    // full with simultaneous push and pop
    cyc(0, 0, 1, 128'd999, 1);
    chk("fullpp_fill", 128'(fill), 16);
    chk("fullpp_drop", 128'(dropc), 4);
    chk("fullpp_head", odata, 101);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_order%0d", i), odata, (i == 15) ? 128'd999 : 128'(101 + i));
      cyc(0, 0, 0, 0, 1);
    end
    chk("drained_fill", 128'(fill), 0);
    chk("drained_valid", 128'(ovalid), 0);

    // stop -> DRAIN -> DONE keeps overflow, then restart clears it
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("done1_state", 128'(state), 3);
    chk("done1_ovf", 128'(ovf), 1);
    chk("done1_drop", 128'(dropc), 4);
    cyc(1, 0, 0, 0, 0);
    chk("restart_state", 128'(state), 1);
    chk("restart_drop", 128'(dropc), 0);
    chk("restart_ovf", 128'(ovf), 0);

    // 4 records then stop carrying a 5th; rec_valid held during drain
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 128'(200 + i), 0);
      exp_q.push_back(128'(200 + i));
    end
    cyc(0, 1, 1, 128'd204, 0);
    exp_q.push_back(128'd204);
    chk("stop_push_fill", 128'(fill), 5);
    chk("stop_state", 128'(state), 2);
    xfers = 0;
    reached = 0;
    for (int c = 0; c < 20 && !reached; c++) begin
      start = 0; stop = 0; rvalid = 1; rdata = 128'(300 + c); ordy = 1;
      #1;
      if (ovalid) begin
        xfers++;
        if (exp_q.size() != 0) chk("drain_data", odata, exp_q.pop_front());
        else chk("drain_extra", odata, 128'hDEAD);
      end
      @(posedge clk); #1;
      if (state == 2'd3) reached = 1;
    end
    chk("drain_reached_done", 128'(reached), 1);
    chk("drain_xfers", 128'(xfers), 5);
    chk("drain_done_o", 128'(done), 1);
    chk("drain_no_drops", 128'(dropc), 0);
    chk("drain_no_ovf", 128'(ovf), 0);

    // reset mid-drain with 7 buffered
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 128'(400 + i), 0);
    cyc(0, 1, 0, 0, 0);
    chk("pre_rst_fill", 128'(fill), 7);
    chk("pre_rst_state", 128'(state), 2);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("mid_rst_state", 128'(state), 0);
    chk("mid_rst_fill", 128'(fill), 0);
    chk("mid_rst_valid", 128'(ovalid), 0);
    chk("mid_rst_drop", 128'(dropc), 0);
    chk("mid_rst_data", odata, 0);
    // start with record on the same cycle, then one real record
    cyc(1, 0, 1, 128'hBAD, 1);
    chk("start_rec_ignored", 128'(fill), 0);
    cyc(0, 0, 1, 128'h77, 0);
    chk("post_rst_head", odata, 128'h77);
    chk("post_rst_fill", 128'(fill), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
